// File: rtl/uart_rx.sv
// UART receive stage: oversampled 8N1 (or 8E1 with UART_RX_PARITY_EN) frame reconstruction.
// UART_RX_PARITY_EN defined adds an even-parity bit between the data bits and the stop bit.
module uart_rx #(
    parameter int unsigned OS_RATE   = 8,
    parameter int unsigned DATA_BITS = 8
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 sample_clk,
    input  logic                 rx,
    output logic [DATA_BITS-1:0] rx_data,
    output logic                 rx_valid,
    output logic                 frame_err,
    output logic                 parity_err,
    output logic                 busy
);

    localparam int unsigned TICK_W = (OS_RATE > 2) ? $clog2(OS_RATE) : 1;
    localparam int unsigned BIT_W  = $clog2(DATA_BITS + 1);
    localparam logic [TICK_W-1:0] TICK_MID  = TICK_W'(OS_RATE / 2 - 1);
    localparam logic [TICK_W-1:0] TICK_LAST = TICK_W'(OS_RATE - 1);
    localparam logic [BIT_W-1:0]  BIT_LAST  = BIT_W'(DATA_BITS - 1);

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_START  = 3'd1,
        S_DATA   = 3'd2,
`ifdef UART_RX_PARITY_EN
        S_PARITY = 3'd3,
`endif
        S_STOP   = 3'd4,
        S_BREAK  = 3'd5
    } state_t;

    logic                 rx_meta, rx_s;
    state_t               state, state_n;
    logic [TICK_W-1:0]    tick_cnt, tick_n;
    logic [BIT_W-1:0]     bit_cnt, bit_n;
    logic [DATA_BITS-1:0] shift, shift_n;
    logic [DATA_BITS-1:0] data_n;
    logic                 valid_n, ferr_n;
`ifdef UART_RX_PARITY_EN
    logic                 par_bad, par_bad_n;
    logic                 perr_n;
`endif

    // Two-flop synchronizer; idles high so reset never looks like a start bit.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rx_meta <= 1'b1;
            rx_s    <= 1'b1;
        end else begin
            rx_meta <= rx;
            rx_s    <= rx_meta;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= S_IDLE;
            tick_cnt  <= '0;
            bit_cnt   <= '0;
            shift     <= '0;
            rx_data   <= '0;
            rx_valid  <= 1'b0;
            frame_err <= 1'b0;
            busy      <= 1'b0;
        end else begin
            state     <= state_n;
            tick_cnt  <= tick_n;
            bit_cnt   <= bit_n;
            shift     <= shift_n;
            rx_data   <= data_n;
            rx_valid  <= valid_n;
            frame_err <= ferr_n;
            busy      <= (state_n != S_IDLE);
        end
    end

`ifdef UART_RX_PARITY_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            par_bad    <= 1'b0;
            parity_err <= 1'b0;
        end else begin
            par_bad    <= par_bad_n;
            parity_err <= perr_n;
        end
    end
`else
    assign parity_err = 1'b0;
`endif

    // Next-state: every decision is gated by a sample tick and consumes it.
    always_comb begin
        state_n = state;
        tick_n  = tick_cnt;
        bit_n   = bit_cnt;
        shift_n = shift;
        data_n  = rx_data;
        valid_n = 1'b0;
        ferr_n  = 1'b0;
`ifdef UART_RX_PARITY_EN
        par_bad_n = par_bad;
        perr_n    = 1'b0;
`endif
        if (sample_clk) begin
            case (state)
                S_IDLE: begin
                    if (!rx_s) begin
                        state_n = S_START;
                        tick_n  = '0;
                    end
                end
                S_START: begin
                    if (tick_cnt == TICK_MID) begin
                        tick_n  = '0;
                        bit_n   = '0;
                        state_n = rx_s ? S_IDLE : S_DATA;
                    end else begin
                        tick_n = tick_cnt + TICK_W'(1);
                    end
                end
                S_DATA: begin
                    if (tick_cnt == TICK_LAST) begin
                        tick_n  = '0;
                        shift_n = {rx_s, shift[DATA_BITS-1:1]};
                        bit_n   = bit_cnt + BIT_W'(1);
                        if (bit_cnt == BIT_LAST) begin
`ifdef UART_RX_PARITY_EN
                            state_n = S_PARITY;
`else
                            state_n = S_STOP;
`endif
                        end
                    end else begin
                        tick_n = tick_cnt + TICK_W'(1);
                    end
                end
`ifdef UART_RX_PARITY_EN
                S_PARITY: begin
                    if (tick_cnt == TICK_LAST) begin
                        tick_n    = '0;
                        par_bad_n = (^shift) ^ rx_s;
                        state_n   = S_STOP;
                    end else begin
                        tick_n = tick_cnt + TICK_W'(1);
                    end
                end
`endif
                S_STOP: begin
                    if (tick_cnt == TICK_LAST) begin
                        tick_n = '0;
                        if (rx_s) begin
                            data_n  = shift;
                            valid_n = 1'b1;
`ifdef UART_RX_PARITY_EN
                            perr_n  = par_bad;
`endif
                            state_n = S_IDLE;
                        end else begin
                            ferr_n  = 1'b1;
                            state_n = S_BREAK;
                        end
                    end else begin
                        tick_n = tick_cnt + TICK_W'(1);
                    end
                end
                // Wait for the line to recover so a held-low line is not a new start.
                S_BREAK: begin
                    if (rx_s) begin
                        state_n = S_IDLE;
                    end
                end
                default: begin
                    state_n = S_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_uart_rx.sv
// Self-checking bench for uart_rx: table of frames plus glitch, break and reset sequences.
// Parity frames are sent when UART_RX_PARITY_EN is defined.
module tb_uart_rx;

    localparam int unsigned OS = 8;
    localparam int unsigned DW = 8;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          sample_clk = 1'b0;
    logic          rx = 1'b1;
    logic [DW-1:0] rx_data;
    logic          rx_valid;
    logic          frame_err;
    logic          parity_err;
    logic          busy;

    uart_rx #(.OS_RATE(OS), .DATA_BITS(DW)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .sample_clk (sample_clk),
        .rx         (rx),
        .rx_data    (rx_data),
        .rx_valid   (rx_valid),
        .frame_err  (frame_err),
        .parity_err (parity_err),
        .busy       (busy)
    );

    always #10 clk = ~clk;

    typedef struct {
        logic [7:0] data;
        logic       ferr;
        logic       perr;
    } exp_t;

    typedef struct {
        logic [7:0]  data;
        logic        pflip;
        int unsigned period;
    } vec_t;

    exp_t        exp_q[$];
    exp_t        e;
    logic [7:0]  last_good = 8'h00;
    int unsigned passed = 0;
    int unsigned total = 0;
    int unsigned period = 10;
    int unsigned tick_count = 0;

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] want);
        total++;
        if (got == want) passed++;
        else $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, got, want, $time);
    endtask

    function automatic logic exp_perr(input logic pflip);
`ifdef UART_RX_PARITY_EN
        return pflip;
`else
        return 1'b0 & pflip;
`endif
    endfunction

    // Tick generator: one-cycle strobe every `period` clocks, driven on the falling edge.
    initial begin
        int unsigned cnt;
        cnt = 0;
        forever begin
            @(negedge clk);
            cnt++;
            if (cnt >= period) begin
                cnt = 0;
                sample_clk = 1'b1;
                tick_count++;
            end else begin
                sample_clk = 1'b0;
            end
        end
    end

    // Scoreboard: every output pulse must match the oldest expected event.
    always @(posedge clk) begin
        #1;
        if (!rst_n) begin
            last_good = 8'h00;
        end else if (rx_valid || frame_err || parity_err) begin
            if (exp_q.size() == 0) begin
                check("unexpected_event", {29'd0, rx_valid, frame_err, parity_err}, 32'd0);
            end else begin
                e = exp_q.pop_front();
                check("rx_valid", rx_valid, !e.ferr);
                check("frame_err", frame_err, e.ferr);
                check("parity_err", parity_err, e.perr);
                if (!e.ferr) last_good = e.data;
                check("rx_data", rx_data, last_good);
            end
        end
    end

    initial begin
        #5ms;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "watchdog");
    end

    task automatic wait_ticks(input int unsigned n);
        int unsigned target;
        target = tick_count + n;
        while (tick_count < target) @(posedge clk);
    endtask

    task automatic drive_bit(input logic v);
        @(negedge clk);
        rx = v;
        wait_ticks(OS);
    endtask

    task automatic send_frame(input logic [7:0] d, input logic pflip, input logic stop);
        drive_bit(1'b0);
        for (int i = 0; i < 8; i++) drive_bit(d[i]);
`ifdef UART_RX_PARITY_EN
        drive_bit((^d) ^ pflip);
`endif
        drive_bit(stop);
    endtask

    vec_t vecs[6];

    initial begin
        vecs[0] = '{data: 8'hA5, pflip: 1'b0, period: 652};
        vecs[1] = '{data: 8'h00, pflip: 1'b0, period: 10};
        vecs[2] = '{data: 8'hFF, pflip: 1'b0, period: 10};
        vecs[3] = '{data: 8'h03, pflip: 1'b1, period: 10};
        vecs[4] = '{data: 8'h03, pflip: 1'b0, period: 10};
        vecs[5] = '{data: 8'hC3, pflip: 1'b0, period: 10};

        rst_n = 1'b0;
        repeat (5) @(posedge clk);
        #1;
        check("reset_rx_data", rx_data, 8'h00);
        check("reset_rx_valid", rx_valid, 1'b0);
        check("reset_frame_err", frame_err, 1'b0);
        check("reset_parity_err", parity_err, 1'b0);
        check("reset_busy", busy, 1'b0);
        @(negedge clk);
        rst_n = 1'b1;
        wait_ticks(4);

        // Back-to-back frames, no idle gap between entries.
        for (int i = 0; i < 6; i++) begin
            period = vecs[i].period;
            exp_q.push_back('{data: vecs[i].data, ferr: 1'b0, perr: exp_perr(vecs[i].pflip)});
            send_frame(vecs[i].data, vecs[i].pflip, 1'b1);
        end
        wait_ticks(4);
        check("frames_idle_busy", busy, 1'b0);
        check("frames_last_data", rx_data, 8'hC3);

        // Two-tick low glitch is rejected at the start-bit middle.
        @(negedge clk);
        rx = 1'b0;
        wait_ticks(2);
        @(negedge clk);
        rx = 1'b1;
        wait_ticks(1);
        check("glitch_busy", busy, 1'b1);
        wait_ticks(4);
        check("glitch_idle", busy, 1'b0);
        check("glitch_hold", rx_data, last_good);

        // Stop bit low, line held low, then released.
        exp_q.push_back('{data: 8'h3C, ferr: 1'b1, perr: 1'b0});
        send_frame(8'h3C, 1'b0, 1'b0);
        wait_ticks(20);
        check("break_busy", busy, 1'b1);
        check("break_hold", rx_data, 8'hC3);
        @(negedge clk);
        rx = 1'b1;
        wait_ticks(3);
        check("break_exit", busy, 1'b0);

        // Reset in the middle of data bit 4, then a clean frame.
        drive_bit(1'b0);
        for (int i = 0; i < 4; i++) drive_bit(8'h5A >> i);
        @(negedge clk);
        rx = 1'b0;
        wait_ticks(4);
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        check("midreset_busy", busy, 1'b0);
        check("midreset_rx_data", rx_data, 8'h00);
        check("midreset_rx_valid", rx_valid, 1'b0);
        rx = 1'b1;
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        wait_ticks(4);
        check("postreset_busy", busy, 1'b0);
        exp_q.push_back('{data: 8'h5A, ferr: 1'b0, perr: 1'b0});
        send_frame(8'h5A, 1'b0, 1'b1);
        wait_ticks(4);
        check("postreset_rx_data", rx_data, 8'h5A);
        check("queue_empty", 32'(exp_q.size()), 32'd0);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule

// File: doc/uart_rx.md
# uart_rx

Serial receive stage of the UART path. Consumes the one-cycle `sample_clk` strobe from the baud/sample divider (8 strobes per bit, 9600 baud at 50 MHz) as a clock enable. Reconstructs 8N1 frames from the asynchronous `rx` line and hands each byte downstream as a one-cycle valid pulse with frame-error status. Runs entirely in the `clk` domain; no derived clocks.

## Interface
- `OS_RATE`, 8: sample strobes per bit; must be even, ≥4.
- `DATA_BITS`, 8: data bits per frame, LSB first.
- `clk`  in  1  system clock, 50 MHz.
- `rst_n`  in  1  asynchronous, active-low reset; one clock domain.
- `sample_clk`  in  1  one-`clk`-cycle enable strobe, 8× bit rate.
- `rx`  in  1  asynchronous serial line, idle high.
- `rx_data`  out  `DATA_BITS`  last good byte; holds until the next good frame.
- `rx_valid`  out  1  one-cycle pulse: `rx_data` newly updated.
- `frame_err`  out  1  one-cycle pulse: stop bit sampled low.
- `parity_err`  out  1  one-cycle pulse: parity mismatch (see Configuration).
- `busy`  out  1  high in any state other than IDLE.

## Operation
- `rx` passes through a 2-FF synchronizer (reset value 1) to produce `rx_s`. All decisions use `rx_s` and occur only in cycles where `sample_clk`=1 ("tick").
- Counters: `tick_cnt` (3 bits, counts ticks within a bit) and `bit_cnt` (counts data bits).
- States:
  - IDLE: on a tick with `rx_s`=0, go to START and set `tick_cnt`=0.
  - START: count ticks. When `tick_cnt`=OS_RATE/2−1 (bit middle), sample. If `rx_s`=0, go to DATA with `tick_cnt`=0 and `bit_cnt`=0. If `rx_s`=1, treat as a glitch and return to IDLE with no output.
  - DATA: every OS_RATE ticks (`tick_cnt`=OS_RATE−1), shift `rx_s` into the MSB of the shift register (right shift, LSB first) and increment `bit_cnt`. After `DATA_BITS` samples, go to PARITY if configured, otherwise to STOP.
  - PARITY: after OS_RATE ticks, sample the parity bit, then go to STOP.
  - STOP: after OS_RATE ticks, sample.
    - `rx_s`=1: load `rx_data` from the shift register, pulse `rx_valid`, go to IDLE.
    - `rx_s`=0: pulse `frame_err`, leave `rx_data` unchanged, go to BREAK.
  - BREAK: stay until a tick sees `rx_s`=1, then go to IDLE. This prevents a held-low line from being re-detected as a new start bit.
- A parity failure pulses `parity_err` in the same cycle that `rx_valid` would pulse. `rx_valid` is still asserted and `rx_data` is still updated.
- A tick arriving in the same cycle as a state transition is consumed by that transition only.
- `sample_clk` pulses closer than 2 cycles apart are not supported.

## Timing
- Reset values: `rx_data`=0, `rx_valid`=0, `frame_err`=0, `parity_err`=0, `busy`=0, state=IDLE, sync FFs=1, counters=0.
- Synchronizer latency: 2 `clk` cycles from `rx` to `rx_s`.
- Start detection occurs on the first tick after `rx_s` falls. The bit-middle sample follows OS_RATE/2 ticks later.
- `rx_valid`, `frame_err` and `parity_err` are registered. Each rises in the `clk` cycle after the stop-bit sample tick and lasts exactly 1 cycle.
- `rx_data` changes in the same cycle that `rx_valid` rises.
- Frame length: 4 + 8·(DATA_BITS+1 [+1]) ticks from start detection to the stop sample. The receiver is back in IDLE at the centre of the stop bit, so a back-to-back frame is detected without loss.
- Asserting `rst_n` low at any point returns all outputs to reset values immediately. A partially received frame is discarded.

## Configuration
- `UART_RX_PARITY_EN`:
  - Defined: PARITY state is present; one even-parity bit is expected between the data bits and the stop bit. `parity_err` pulses when the XOR of the data bits and the parity bit is 1.
  - Undefined: PARITY state is removed, the frame is 8N1, and `parity_err` is tied to 0.

## Test plan
- Send 0xA5 in 8N1, 652-cycle tick period -> exactly one `rx_valid` pulse, `rx_data`=0xA5, `frame_err`=0.
- Drive `rx` low for 2 ticks then high -> no `rx_valid`, `busy` returns to 0, `rx_data` unchanged.
- Send 0x3C with stop bit low, then hold `rx` low for 20 ticks, then high -> one `frame_err` pulse, `rx_data` still holds the previous value, no spurious start detection until the line goes high.
- Send 0x00 and 0xFF back-to-back with no idle gap -> two `rx_valid` pulses with data 0x00 then 0xFF.
- Assert `rst_n` low in the middle of data bit 4, release, then send 0x5A -> no output from the aborted frame, then `rx_data`=0x5A.
- With `UART_RX_PARITY_EN` defined, send 0x03 with parity bit 1 -> `rx_valid` and `parity_err` pulse together, `rx_data`=0x03. With parity bit 0 -> `parity_err`=0.
